// File: rtl/red_pitaya_fads_sort_sched_if.sv
// red_pitaya_fads_sort_sched_if: system bus bundle between bus master and the sort scheduler
interface red_pitaya_fads_sort_sched_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic [3:0]  sys_sel;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;
  modport master (output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren, input sys_rdata, sys_err, sys_ack);
  modport slave (input sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren, output sys_rdata, sys_err, sys_ack);
endinterface

// File: rtl/red_pitaya_fads_sort_sched.sv
// red_pitaya_fads_sort_sched: queues positive droplets and fires ordered delayed sort pulses; FADS_SCHED_MANUAL_EN adds a manual push at 0x1C
module red_pitaya_fads_sort_sched #(
  parameter int QDW = 3,
  parameter int TSW = 32
) (
  input  logic adc_clk_i,
  input  logic adc_rstn_i,
  input  logic drop_done_i,
  input  logic drop_pos_i,
  output logic sort_trig,
  output logic sched_busy_o,
  red_pitaya_fads_sort_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, FIRE = 2'd2, GAP = 2'd3} state_t;
  localparam int QN = 1 << QDW;
  localparam logic [TSW-1:0] HALF = {1'b1, {(TSW-1){1'b0}}};
  state_t state_q, state_d;
  logic [TSW-1:0] ts_q, ts_d, delay_q, delay_d, width_q, width_d, gap_q, gap_d;
  logic [TSW-1:0] tmr_q, tmr_d, sort_cnt_q, sort_cnt_d, ovf_cnt_q, ovf_cnt_d, head, wmax;
  logic [TSW-1:0] mem_q [QN];
  logic [TSW-1:0] mem_d [QN];
  logic [TSW:0] ovf_sum;
  logic [QDW:0] wp_q, wp_d, rp_q, rp_d, fill;
  logic [31:0] rdata_q, rdata_d;
  logic [19:0] a;
  logic en_q, en_d, trig_q, trig_d, ack_q, ack_d;
  logic wr, ctrl_wr, abort, clr, empty, full, due, req, extra, launch, fired, push, pop, lost;
  logic unused;
  assign unused = ^{bus.sys_sel, bus.sys_addr[31:20]};
  assign sort_trig = trig_q;
  assign sched_busy_o = !empty || state_q != IDLE;
  assign bus.sys_rdata = rdata_q;
  assign bus.sys_ack = ack_q;
  assign bus.sys_err = 1'b0;
  always_comb begin
    a = bus.sys_addr[19:0];
    wr = bus.sys_wen;
    ctrl_wr = wr && a == 20'h0;
    abort = ctrl_wr && !bus.sys_wdata[0];
    clr = ctrl_wr && bus.sys_wdata[1];
    fill = wp_q - rp_q;
    empty = fill == '0;
    full = fill[QDW];
    head = mem_q[rp_q[QDW-1:0]];
    due = !empty && (ts_q - head) < HALF;
    wmax = width_q == '0 ? TSW'(1) : width_q;
`ifdef FADS_SCHED_MANUAL_EN
    req = en_q && ((drop_done_i && drop_pos_i) || (wr && a == 20'h1C));
    extra = en_q && drop_done_i && drop_pos_i && wr && a == 20'h1C && !abort;
`else
    req = en_q && drop_done_i && drop_pos_i;
    extra = 1'b0;
`endif
    launch = due && (state_q == ARMED || (state_q == GAP && tmr_q == TSW'(1)));
    fired = state_q == FIRE && tmr_q == TSW'(1);
    pop = launch && !abort;
    trig_d = !abort && (launch || (trig_q && !fired));
    tmr_d = launch ? wmax : fired ? gap_q : tmr_q - TSW'(1);
    state_d = abort ? IDLE : launch ? FIRE : fired ? (gap_q == '0 ? IDLE : GAP) :
              (state_q == IDLE && !empty) ? ARMED : (state_q == GAP && tmr_q == TSW'(1)) ? IDLE : state_q;
    push = req && !abort && (!full || pop);
    lost = req && !abort && full && !pop;
    wp_d = abort ? '0 : wp_q + (QDW+1)'(push);
    rp_d = abort ? '0 : rp_q + (QDW+1)'(pop);
    mem_d = mem_q;
    if (push) mem_d[wp_q[QDW-1:0]] = ts_q + delay_q;
    ts_d = ts_q + TSW'(1);
    ovf_sum = {1'b0, ovf_cnt_q} + (TSW+1)'(lost) + (TSW+1)'(extra);
    ovf_cnt_d = clr ? '0 : ovf_sum[TSW] ? '1 : ovf_sum[TSW-1:0];
    sort_cnt_d = clr ? '0 : sort_cnt_q + TSW'(fired && !abort);
    en_d = ctrl_wr ? bus.sys_wdata[0] : en_q;
    delay_d = (wr && a == 20'h4) ? TSW'(bus.sys_wdata) : delay_q;
    width_d = (wr && a == 20'h8) ? TSW'(bus.sys_wdata) : width_q;
    gap_d = (wr && a == 20'hC) ? TSW'(bus.sys_wdata) : gap_q;
    ack_d = bus.sys_wen || bus.sys_ren;
    rdata_d = !bus.sys_ren ? 32'h0 : a == 20'h0 ? {31'h0, en_q} : a == 20'h4 ? 32'(delay_q) :
              a == 20'h8 ? 32'(width_q) : a == 20'hC ? 32'(gap_q) :
              a == 20'h10 ? ((32'(state_q) << 16) | 32'(fill)) :
              a == 20'h14 ? 32'(sort_cnt_q) : a == 20'h18 ? 32'(ovf_cnt_q) : 32'h0;
  end
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state_q <= IDLE;
      ts_q <= '0;
      delay_q <= TSW'(1250);
      width_q <= TSW'(125);
      gap_q <= '0;
      tmr_q <= '0;
      sort_cnt_q <= '0;
      ovf_cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      mem_q <= '{default: '0};
      en_q <= 1'b0;
      trig_q <= 1'b0;
      ack_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ts_q <= ts_d;
      delay_q <= delay_d;
      width_q <= width_d;
      gap_q <= gap_d;
      tmr_q <= tmr_d;
      sort_cnt_q <= sort_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      mem_q <= mem_d;
      en_q <= en_d;
      trig_q <= trig_d;
      ack_q <= ack_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_red_pitaya_fads_sort_sched.sv
// tb_red_pitaya_fads_sort_sched: directed and randomized checks of pulse timing, ordering, overflow, wrap and bus
module tb_red_pitaya_fads_sort_sched;
  logic clk = 0, rst_n = 0, drop_done = 0, drop_pos = 0;
  logic sort_trig, busy;
  red_pitaya_fads_sort_sched_if bus ();
  red_pitaya_fads_sort_sched dut (
    .adc_clk_i(clk), .adc_rstn_i(rst_n), .drop_done_i(drop_done), .drop_pos_i(drop_pos),
    .sort_trig(sort_trig), .sched_busy_o(busy), .bus(bus)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic [31:0] tsm = 0, last_st = 0, rd, t;
  logic pt = 0;
  logic [31:0] st_q[$], ln_q[$], tg_q[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      tsm++;
      @(negedge clk);
      if (sort_trig && !pt) begin
        st_q.push_back(tsm);
        last_st = tsm;
      end
      if (!sort_trig && pt) ln_q.push_back(tsm - last_st);
      pt = sort_trig;
    end
  endtask
  task automatic drop(input logic pos, input logic rec, input logic [31:0] d);
    drop_done = 1;
    drop_pos = pos;
    if (rec) tg_q.push_back(tsm + d);
    tick();
    drop_done = 0;
    drop_pos = 0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.sys_addr = a;
    bus.sys_wdata = d;
    bus.sys_wen = 1;
    tick();
    bus.sys_wen = 0;
  endtask
  task automatic rdr(input logic [31:0] a, output logic [31:0] d);
    bus.sys_addr = a;
    bus.sys_ren = 1;
    tick();
    bus.sys_ren = 0;
    chk("ack", 32'(bus.sys_ack), 1);
    d = bus.sys_rdata;
  endtask
  task automatic pulses(input string tag, input logic [31:0] w);
    chk({tag, "_n"}, st_q.size(), tg_q.size());
    chk({tag, "_nlen"}, ln_q.size(), st_q.size());
    foreach (st_q[i]) if (i < tg_q.size() && i < ln_q.size()) begin
      chk({tag, "_late"}, 32'((st_q[i] - tg_q[i] - 32'd1) < 32'd128), 1);
      chk({tag, "_len"}, ln_q[i], w);
    end
    st_q.delete();
    ln_q.delete();
    tg_q.delete();
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    bus.sys_addr = 0;
    bus.sys_wdata = 0;
    bus.sys_sel = 4'hF;
    bus.sys_wen = 0;
    bus.sys_ren = 0;
    repeat (2) @(negedge clk);
    chk("rst_trig", 32'(sort_trig), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(bus.sys_ack), 0);
    rst_n = 1;
    rdr(4, rd); chk("rst_delay", rd, 1250);
    rdr(8, rd); chk("rst_width", rd, 125);
    rdr(12, rd); chk("rst_gap", rd, 0);
    rdr(0, rd); chk("rst_ctrl", rd, 0);
    rdr(16, rd); chk("rst_status", rd, 0);
    wr(0, 3); wr(4, 100); wr(8, 10); wr(12, 0);
    t = tsm;
    drop(1, 1, 100);
    tick(130);
    chk("basic_start", st_q[0], t + 101);
    pulses("basic", 10);
    rdr(20, rd); chk("basic_cnt", rd, 1);
    chk("basic_busy", 32'(busy), 0);
    drop(0, 0, 100);
    rdr(16, rd); chk("neg_fill", rd, 0);
    tick(120);
    pulses("neg", 10);
    wr(0, 3); wr(4, 200); wr(8, 20); wr(12, 30);
    t = tsm;
    drop(1, 1, 200);
    tick(4);
    drop(1, 1, 200);
    tick(320);
    chk("b2b_st0", st_q[0], t + 201);
    chk("b2b_st1", st_q[1], t + 251);
    pulses("b2b", 20);
    rdr(20, rd); chk("b2b_cnt", rd, 2);
    wr(0, 3); wr(4, 10000); wr(8, 10); wr(12, 0);
    for (int i = 0; i < 10; i++) drop(1, i < 8, 10000);
    rdr(16, rd); chk("ovf_status", rd, 32'h10008);
    rdr(24, rd); chk("ovf_cnt", rd, 2);
    tick(10150);
    pulses("ovf", 10);
    rdr(20, rd); chk("ovf_sort", rd, 8);
    for (int r = 0; r < 4; r++) begin
      int d, w, g, n;
      d = int'($urandom_range(60, 20));
      w = int'($urandom_range(15, 0));
      g = int'($urandom_range(10, 0));
      n = 0;
      wr(0, 3); wr(4, d); wr(8, w); wr(12, g);
      for (int k = 0; k < 25; k++) begin
        logic p;
        p = 1'($urandom_range(1, 0));
        if (p) n++;
        drop(p, p, d);
        tick(int'($urandom_range(w + g + 40, w + g + 9)));
      end
      tick(200);
      pulses("rnd", w == 0 ? 1 : w);
      rdr(20, rd); chk("rnd_cnt", rd, n);
      rdr(24, rd); chk("rnd_ovf", rd, 0);
    end
    wr(0, 0); wr(0, 1); wr(4, 100); wr(8, 10); wr(12, 0);
    force dut.ts_q = 32'hFFFF_FFCE;
    tsm = 32'hFFFF_FFCE;
    #1 release dut.ts_q;
    t = tsm;
    drop(1, 1, 100);
    drop(1, 0, 100);
    tick(103);
    chk("wrap_start", st_q[0], t + 101);
    chk("wrap_n", st_q.size(), 1);
    wr(0, 0);
    chk("abort_trig", 32'(sort_trig), 0);
    rdr(16, rd); chk("abort_status", rd, 0);
    chk("abort_busy", 32'(busy), 0);
    tick(150);
    chk("abort_none", st_q.size(), 1);
    st_q.delete(); ln_q.delete(); tg_q.delete();
    wr(0, 1); wr(4, 20); wr(8, 0);
    drop(1, 1, 20);
    tick(40);
    pulses("w0", 1);
    tick();
    chk("idle_ack", 32'(bus.sys_ack), 0);
    rdr(32'h20, rd); chk("unmapped_rd", rd, 0);
    wr(32'h20, 32'hDEAD);
    rdr(4, rd); chk("unmapped_wr", rd, 20);
    rdr(20, rd); chk("pre_clr_sort", 32'(rd != 0), 1);
    wr(0, 3);
    rdr(20, rd); chk("clr_sort", rd, 0);
    rdr(24, rd); chk("clr_ovf", rd, 0);
    rdr(0, rd); chk("ctrl_rd", rd, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/red_pitaya_fads_sort_sched.md
Name: red_pitaya_fads_sort_sched

Overview:
- Sort-trigger scheduler between the FADS droplet classifier and the ASG/HV-amplifier trigger.
- Each positive droplet arriving from the classifier is time-stamped and queued, then fired as a sort pulse after a programmable flight delay.
- Several droplets can be in flight between detector and sorting electrode at once; pulses stay ordered and never overlap.
- Delay, pulse width, holdoff and counters are exposed on the system bus.

Parameters:
- QDW, 3, log2 of the pending-event queue depth (8 entries).
- TSW, 32, width of the timestamp counter and of the delay/width/gap registers.

Ports:
- adc_clk_i  in  1  ADC clock; only clock.
- adc_rstn_i  in  1  reset, asynchronous, active-low.
- drop_done_i  in  1  one-cycle pulse: classifier finished a droplet.
- drop_pos_i  in  1  droplet is positive; qualified by drop_done_i.
- sort_trig  out  1  sort pulse to ASG trigger.
- sched_busy_o  out  1  queue non-empty or FSM not IDLE.
- sys_addr  in  32  bus address.
- sys_wdata  in  32  bus write data.
- sys_sel  in  4  byte select; ignored, writes are full-word.
- sys_wen  in  1  bus write enable.
- sys_ren  in  1  bus read enable.
- sys_rdata  out  32  bus read data.
- sys_err  out  1  always 0.
- sys_ack  out  1  bus acknowledge.

Behaviour:
- Reset (async assert, sync release): all outputs 0, queue empty, FSM IDLE, ts=0, counters 0; enable=0, delay=1250, width=125, gap=0.
- ts: free-running TSW-bit counter, wraps modulo 2^TSW.
- Push: on drop_done_i & drop_pos_i & enable, write ts+delay (mod 2^TSW) into the FIFO tail.
  - If the FIFO is full, the event is discarded and ovf_cnt increments (saturating at all-ones).
  - Push and pop in the same cycle are both honoured, including when full.
- FSM IDLE -> ARMED when the FIFO is non-empty.
- FSM ARMED: due = (ts - head) MSB clear (wrap-safe, head reached or passed).
  - When due: pop, load tmr=max(width,1), sort_trig=1 from the next cycle, go FIRE.
  - An already-late head fires immediately.
- FSM FIRE: tmr decrements; when it reaches 1, sort_trig=0 and sort_cnt increments.
  - Go to GAP if gap≠0, else go to IDLE.
  - Pulse length is exactly max(width,1) cycles.
- FSM GAP: hold for gap cycles, then IDLE.
  - A due head waits; it is fired late, never dropped.
- Clearing enable (write ctrl bit0=0) while active: next cycle FIFO is flushed, sort_trig=0, FSM goes IDLE, ts keeps running.
- Register writes to delay/width/gap apply to the next push or pulse; in-flight entries keep their stored target.
- sched_busy_o = !empty | (state≠IDLE).
- Bus: sys_ack is registered and asserts 1 cycle after sys_wen|sys_ren. Unmapped reads return 0 and unmapped writes are ignored.
- Register map (sys_addr[19:0]):
  - 0x00 ctrl: bit0 enable (R/W); bit1 clear sort_cnt/ovf_cnt (write-1, self-clearing, reads 0).
  - 0x04 delay (R/W).
  - 0x08 width (R/W).
  - 0x0C gap (R/W).
  - 0x10 status (RO): [QDW:0] fill level, [17:16] state (IDLE=0, ARMED=1, FIRE=2, GAP=3).
  - 0x14 sort_cnt (RO).
  - 0x18 ovf_cnt (RO).
  - Clear and a same-cycle counter increment: clear wins.

Optional Feature:
- Macro: FADS_SCHED_MANUAL_EN.
- With the macro defined: write-only register 0x1C; any write while enable=1 performs a push exactly as a positive droplet would.
  - Same cycle as drop_done_i&drop_pos_i: two pushes would be needed, so the manual push is taken and the droplet is counted in ovf_cnt.
  - Reads of 0x1C return 0.
- Without the macro: 0x1C is unmapped and no manual path exists.

Test Plan:
- Basic: enable=1, delay=100, width=10, gap=0; one positive pulse at ts=T -> sort_trig high cycles T+101..T+110, sort_cnt=1, busy low afterwards.
- Negative droplet: drop_pos_i=0 -> no pulse, status fill stays 0.
- Back-to-back: delay=200, width=20, gap=30; positives at T and T+5 -> first pulse at T+201 for 20 cycles; second delayed until GAP ends, starting at T+251; sort_cnt=2.
- Overflow: delay=10000; 10 positives -> fill=8, ovf_cnt=2, exactly 8 pulses, in order.
- Wrap and abort:
  - Force ts near 2^32-50 (via reset then long run or hierarchical preload), delay=100 -> pulse 101 cycles later across the wrap.
  - Then clear enable mid-pulse -> sort_trig=0 next cycle, fill=0, state=IDLE.
- Bus: write width=0 -> 1-cycle pulse; read 0x20 -> 0 with sys_ack 1 cycle after sys_ren; write ctrl=0x3 -> counters read 0, bit1 reads 0.
